sram_arbiter_seq: RTL and testbench

//  Shares the external 16-bit SRAM core (sram) between two 32-bit native-bus requesters:

---
 rtl/sram_arbiter_seq_pkg.sv | 48 ++++
 rtl/sram_arbiter_seq_port_arbiter.sv | 53 +++++
 rtl/sram_arbiter_seq.sv | 207 ++++++++++++++++++++
 tb/tb_sram_arbiter_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_seq_pkg.sv
// Shared FSM encodings, access codes and plan/merge helpers for the SRAM arbiter.
// Plan slots are ordered {hi WR, hi RD, lo WR, lo RD}; bit1 of a slot index is the half, bit0 the op.
package sram_arbiter_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic ACC_RD = 1'b0;
  localparam logic ACC_WR = 1'b1;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  // A word read touches both halves; a partial halfword strobe needs RD before WR.
  function automatic logic [3:0] build_plan(input logic [3:0] wstrb);
    logic [3:0] plan;
    if (wstrb == 4'b0000) begin
      plan = 4'b0101;
    end else begin
      plan[0] = ^wstrb[1:0];
      plan[1] = |wstrb[1:0];
      plan[2] = ^wstrb[3:2];
      plan[3] = |wstrb[3:2];
    end
    return plan;
  endfunction

  function automatic logic [1:0] lowest_slot(input logic [3:0] mask);
    logic [1:0] slot;
    if (mask[0])      slot = 2'd0;
    else if (mask[1]) slot = 2'd1;
    else if (mask[2]) slot = 2'd2;
    else              slot = 2'd3;
    return slot;
  endfunction

  function automatic logic [15:0] merge_half(input logic [15:0] old_half,
                                             input logic [15:0] new_half,
                                             input logic [1:0]  strb);
    return {strb[1] ? new_half[15:8] : old_half[15:8],
            strb[0] ? new_half[7:0]  : old_half[7:0]};
  endfunction

endpackage

// File: rtl/sram_arbiter_seq_port_arbiter.sv
// Two-way fixed-priority arbiter (port 0 first) with a saturating starvation counter for port 1.
// Decision registered: gnt_valid pulses the cycle after an enabled arbitration; no backpressure.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          gnt_id_q, gnt_id_d;
  logic          pick1;

  always_comb begin
    starve_d    = starve_q;
    gnt_valid_d = 1'b0;
    gnt_id_d    = gnt_id_q;
    pick1       = req[1] && (!req[0] || (starve_q == LIMIT));
    if (grant_en && (req != 2'b00)) begin
      gnt_valid_d = 1'b1;
      gnt_id_d    = pick1;
      if (pick1 || !req[1]) begin
        starve_d = '0;
      end else if (starve_q != LIMIT) begin
        starve_d = starve_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q    <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: rtl/sram_arbiter_seq.sv
// Shares a 16-bit SRAM core between two 32-bit native-bus ports, one halfword access at a time.
// Ready pulses 2+3N cycles after grant with an idle core; masters hold valid until their ready pulse.
module sram_arbiter_seq
  import sram_arbiter_seq_pkg::*;
#(
  parameter int AW           = 18,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic [3:0]    p0_wstrb,
  input  logic [31:0]   p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic [31:0]   p0_rdata,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic [3:0]    p1_wstrb,
  input  logic [31:0]   p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic [31:0]   p1_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [15:0]   mem_data_write,
  input  logic [15:0]   mem_data_read,
  input  logic          mem_ready,
  output logic          grant,
  output logic          busy
);

  logic [1:0]    state_q, state_d;
  logic          wait_first_q, wait_first_d;
  logic          gnt_id_q, gnt_id_d;
  req_t          req_q, req_d;
  logic [AW-2:0] waddr_q, waddr_d;
  logic [3:0]    remain_q, remain_d;
  logic [15:0]   lo_buf_q, lo_buf_d;
  logic [15:0]   hi_buf_q, hi_buf_d;
  logic [31:0]   p0_rdata_q, p0_rdata_d;
  logic [31:0]   p1_rdata_q, p1_rdata_d;
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic [15:0]   mem_data_write_q, mem_data_write_d;

  logic          arb_gnt_valid;
  logic          arb_gnt_id;
  logic          grant_en;
  logic [1:0]    cur_slot;
  logic [1:0]    load_slot;
  logic [3:0]    nxt_remain;
  logic [3:0]    load_mask;
  logic          load_en;
  logic [15:0]   load_old;
  logic [31:0]   done_rdata;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{p0_addr[31:AW+1], p0_addr[1:0], p1_addr[31:AW+1], p1_addr[1:0]};

  // Hold off arbitration while a registered grant is in flight to the FSM.
  assign grant_en = (state_q == ST_IDLE) && !arb_gnt_valid;

  sram_port_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_port_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       ({p1_valid, p0_valid}),
    .grant_en  (grant_en),
    .gnt_valid (arb_gnt_valid),
    .gnt_id    (arb_gnt_id)
  );

  assign cur_slot   = lowest_slot(remain_q);
  assign nxt_remain = remain_q & ~(4'b0001 << cur_slot);

  always_comb begin
    state_d          = state_q;
    wait_first_d     = wait_first_q;
    gnt_id_d         = gnt_id_q;
    req_d            = req_q;
    waddr_d          = waddr_q;
    remain_d         = remain_q;
    lo_buf_d         = lo_buf_q;
    hi_buf_d         = hi_buf_q;
    p0_rdata_d       = p0_rdata_q;
    p1_rdata_d       = p1_rdata_q;
    mem_address_d    = mem_address_q;
    mem_data_write_d = mem_data_write_q;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    load_en          = 1'b0;
    load_mask        = 4'b0000;
    load_old         = 16'h0000;
    load_slot        = 2'd0;
    done_rdata       = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (arb_gnt_valid) begin
          gnt_id_d = arb_gnt_id;
          if (arb_gnt_id) begin
            req_d.wstrb = p1_wstrb;
            req_d.wdata = p1_wdata;
            waddr_d     = p1_addr[AW:2];
          end else begin
            req_d.wstrb = p0_wstrb;
            req_d.wdata = p0_wdata;
            waddr_d     = p0_addr[AW:2];
          end
          remain_d  = build_plan(req_d.wstrb);
          load_en   = 1'b1;
          load_mask = remain_d;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          mem_read     = (cur_slot[0] == ACC_RD);
          mem_write    = (cur_slot[0] == ACC_WR);
          wait_first_d = 1'b1;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The core may still report ready in the cycle right after the strobe.
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (mem_ready) begin
          if (cur_slot[0] == ACC_RD) begin
            if (cur_slot[1]) hi_buf_d = mem_data_read;
            else             lo_buf_d = mem_data_read;
          end
          remain_d = nxt_remain;
          if (nxt_remain == 4'b0000) begin
            done_rdata = {hi_buf_d, lo_buf_d};
            if (gnt_id_q) p1_rdata_d = done_rdata;
            else          p0_rdata_d = done_rdata;
            state_d = ST_DONE;
          end else begin
            // A partial-strobe write always directly follows the read of its own half.
            load_en   = 1'b1;
            load_mask = nxt_remain;
            load_old  = mem_data_read;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_en) begin
      load_slot     = lowest_slot(load_mask);
      mem_address_d = {waddr_d, load_slot[1]};
      if (load_slot[1]) begin
        mem_data_write_d = merge_half(load_old, req_d.wdata[31:16], req_d.wstrb[3:2]);
      end else begin
        mem_data_write_d = merge_half(load_old, req_d.wdata[15:0], req_d.wstrb[1:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      wait_first_q     <= 1'b0;
      gnt_id_q         <= 1'b0;
      req_q            <= '0;
      waddr_q          <= '0;
      remain_q         <= 4'b0000;
      lo_buf_q         <= 16'h0000;
      hi_buf_q         <= 16'h0000;
      p0_rdata_q       <= 32'h0;
      p1_rdata_q       <= 32'h0;
      mem_address_q    <= '0;
      mem_data_write_q <= 16'h0000;
    end else begin
      state_q          <= state_d;
      wait_first_q     <= wait_first_d;
      gnt_id_q         <= gnt_id_d;
      req_q            <= req_d;
      waddr_q          <= waddr_d;
      remain_q         <= remain_d;
      lo_buf_q         <= lo_buf_d;
      hi_buf_q         <= hi_buf_d;
      p0_rdata_q       <= p0_rdata_d;
      p1_rdata_q       <= p1_rdata_d;
      mem_address_q    <= mem_address_d;
      mem_data_write_q <= mem_data_write_d;
    end
  end

  assign p0_ready       = (state_q == ST_DONE) && !gnt_id_q;
  assign p1_ready       = (state_q == ST_DONE) &&  gnt_id_q;
  assign p0_rdata       = p0_rdata_q;
  assign p1_rdata       = p1_rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_data_write = mem_data_write_q;
  assign grant          = gnt_id_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter_seq.sv
// Directed bench for sram_arbiter_seq with a behavioural 256Kx16 SRAM core model.
module tb_sram_arbiter_seq;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_valid, p0_ready, p1_valid, p1_ready;
  logic [3:0]    p0_wstrb, p1_wstrb;
  logic [31:0]   p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
  logic          mem_read, mem_write, mem_ready, grant, busy;
  logic [AW-1:0] mem_address;
  logic [15:0]   mem_data_write;
  logic [15:0]   mem_data_read = 16'h0000;

  always #5 clk = ~clk;

  sram_arbiter_seq #(.AW(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_wstrb(p0_wstrb), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_wstrb(p1_wstrb), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_write(mem_data_write), .mem_data_read(mem_data_read), .mem_ready(mem_ready),
    .grant(grant), .busy(busy)
  );

  // SRAM core model: strobe at cycle s -> mem_ready low for 1+stall cycles, high again after.
  logic [15:0]   sram [0:(1<<AW)-1];
  int            stall = 0;
  int            cnt = 0;
  int            rd_cnt = 0, wr_cnt = 0, both_err = 0, stab_err = 0;
  logic          last_wr = 1'b0;
  logic [15:0]   hold_dat = 16'h0000;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [15:0]   pl_dat = 16'h0000;

  assign mem_ready = (cnt == 0);

  always @(posedge clk) begin
    if (mem_read && mem_write) both_err <= both_err + 1;
    if (cnt > 0) begin
      if (last_wr && (mem_data_write != hold_dat)) stab_err <= stab_err + 1;
      cnt <= cnt - 1;
    end
    if (pl_en) sram[pl_addr] <= pl_dat;
    if (mem_read) begin
      rd_cnt        <= rd_cnt + 1;
      mem_data_read <= sram[mem_address];
      last_wr       <= 1'b0;
      cnt           <= 1 + stall;
    end else if (mem_write) begin
      wr_cnt             <= wr_cnt + 1;
      sram[mem_address]  <= mem_data_write;
      hold_dat           <= mem_data_write;
      last_wr            <= 1'b1;
      cnt                <= 1 + stall;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] haddr, input logic [15:0] dat);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = haddr; pl_dat = dat;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_txn(input bit port, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat,
                        output int nrd, output int nwr);
    int r0, w0;
    bit done;
    r0 = rd_cnt; w0 = wr_cnt;
    rd = 32'h0;
    @(negedge clk);
    if (port) begin p1_addr = addr; p1_wstrb = strb; p1_wdata = wd; p1_valid = 1'b1; end
    else      begin p0_addr = addr; p0_wstrb = strb; p0_wdata = wd; p0_valid = 1'b1; end
    lat = 0; done = 1'b0;
    while (!done && lat < 400) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (port ? p1_ready : p0_ready) begin
        done = 1'b1;
        rd = port ? p1_rdata : p0_rdata;
      end
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    check("txn_completed", 32'(done), 32'd1);
    nrd = rd_cnt - r0; nwr = wr_cnt - w0;
  endtask

  logic [31:0] rd;
  int          lat, nrd, nwr;
  int          order [10];
  int          exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int          n, cyc, dup, n0, n1, w0;
  bit          seen_rdy;

  initial begin
    reset = 1'b1;
    p0_valid = 1'b0; p0_wstrb = 4'h0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_valid = 1'b0; p1_wstrb = 4'h0; p1_addr = 32'h0; p1_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_strobes_ready", {28'h0, mem_read, mem_write, p0_ready, p1_ready}, 32'h0);
    check("rst_busy_grant", {30'h0, busy, grant}, 32'h0);
    check("rst_mem_addr_data", {mem_address[15:0], mem_data_write}, 32'h0);
    check("rst_p0_rdata", p0_rdata, 32'h0);
    check("rst_p1_rdata", p1_rdata, 32'h0);

    // 1: full write then read back
    do_txn(1'b0, 32'h100, 4'hF, 32'hDEADBEEF, rd, lat, nrd, nwr);
    check("t1_wr_lat", 32'(lat), 32'd8);
    check("t1_wr_accesses", 32'(nrd * 16 + nwr), 32'h02);
    check("t1_sram_lo", {16'h0, sram[18'h080]}, 32'h0000BEEF);
    check("t1_sram_hi", {16'h0, sram[18'h081]}, 32'h0000DEAD);
    do_txn(1'b0, 32'h100, 4'h0, 32'h0, rd, lat, nrd, nwr);
    check("t1_rd_data", rd, 32'hDEADBEEF);
    check("t1_rd_lat", 32'(lat), 32'd8);
    check("t1_rd_accesses", 32'(nrd * 16 + nwr), 32'h20);

    // address bits above AW alias
    do_txn(1'b0, 32'h0008_0100, 4'h0, 32'h0, rd, lat, nrd, nwr);
    check("wrap_rd_data", rd, 32'hDEADBEEF);

    // 2: single-byte RMW in the low half
    preload(18'h100, 16'h3344);
    preload(18'h101, 16'h1122);
    do_txn(1'b0, 32'h200, 4'b0010, 32'h0000AA00, rd, lat, nrd, nwr);
    check("t2_lat", 32'(lat), 32'd8);
    check("t2_accesses", 32'(nrd * 16 + nwr), 32'h11);
    do_txn(1'b0, 32'h200, 4'h0, 32'h0, rd, lat, nrd, nwr);
    check("t2_rd_data", rd, 32'h1122AA44);

    // 3: RMW in both halves, then hi-only full-halfword write
    preload(18'h120, 16'h3344);
    preload(18'h121, 16'h1122);
    do_txn(1'b0, 32'h240, 4'b0101, 32'h00BB00CC, rd, lat, nrd, nwr);
    check("t3_rmw_lat", 32'(lat), 32'd14);
    check("t3_rmw_accesses", 32'(nrd * 16 + nwr), 32'h22);
    check("t3_rmw_sram", {sram[18'h121], sram[18'h120]}, 32'h11BB33CC);
    do_txn(1'b0, 32'h240, 4'b1100, 32'h55660000, rd, lat, nrd, nwr);
    check("t3_hi_lat", 32'(lat), 32'd5);
    check("t3_hi_accesses", 32'(nrd * 16 + nwr), 32'h01);
    do_txn(1'b0, 32'h240, 4'h0, 32'h0, rd, lat, nrd, nwr);
    check("t3_rd_data", rd, 32'h556633CC);

    // 4: both ports valid continuously, starvation forcing
    preload(18'h280, 16'hF00D);
    preload(18'h281, 16'h0BAD);
    @(negedge clk);
    p0_addr = 32'h100; p0_wstrb = 4'h0; p0_valid = 1'b1;
    p1_addr = 32'h500; p1_wstrb = 4'h0; p1_valid = 1'b1;
    n = 0; cyc = 0; dup = 0; n0 = 0; n1 = 0;
    while (n < 10 && cyc < 600) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (p0_ready && p1_ready) dup++;
      if (p0_ready) begin
        order[n] = 0; n++; n0++;
        check("t4_p0_data", p0_rdata, 32'hDEADBEEF);
      end else if (p1_ready) begin
        order[n] = 1; n++; n1++;
        check("t4_p1_data", p1_rdata, 32'h0BADF00D);
      end
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    check("t4_completions", 32'(n), 32'd10);
    check("t4_dup_ready", 32'(dup), 32'd0);
    check("t4_p0_count", 32'(n0), 32'd8);
    check("t4_p1_count", 32'(n1), 32'd2);
    for (int i = 0; i < n; i++) check($sformatf("t4_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // 5: reset in the WAIT of the hi write aborts the transaction
    w0 = wr_cnt; seen_rdy = 1'b0;
    @(negedge clk);
    p0_addr = 32'h300; p0_wstrb = 4'hF; p0_wdata = 32'hCAFEF00D; p0_valid = 1'b1;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (p0_ready) seen_rdy = 1'b1;
    end
    check("t5_hi_wr_issued", 32'(wr_cnt - w0), 32'd2);
    reset = 1'b1; p0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (p0_ready) seen_rdy = 1'b1;
    check("t5_no_ready", 32'(seen_rdy), 32'd0);
    check("t5_strobes_low", {30'h0, mem_read, mem_write}, 32'h0);
    check("t5_busy_low", 32'(busy), 32'd0);
    check("t5_rdata_cleared", p0_rdata, 32'h0);
    reset = 1'b0;
    do_txn(1'b0, 32'h300, 4'h0, 32'h0, rd, lat, nrd, nwr);
    check("t5_rd_data", rd, 32'hCAFEF00D);
    check("t5_rd_lat", 32'(lat), 32'd8);

    // 6: core stalls 10 extra cycles per access
    preload(18'h200, 16'hC0D0);
    preload(18'h201, 16'hA0B0);
    stall = 10;
    do_txn(1'b1, 32'h400, 4'b0110, 32'h12345678, rd, lat, nrd, nwr);
    check("t6_wr_lat", 32'(lat), 32'd54);
    check("t6_wr_accesses", 32'(nrd * 16 + nwr), 32'h22);
    check("t6_sram", {sram[18'h201], sram[18'h200]}, 32'hA03456D0);
    check("t6_wdata_stable", 32'(stab_err), 32'd0);
    do_txn(1'b1, 32'h400, 4'h0, 32'h0, rd, lat, nrd, nwr);
    check("t6_rd_data", rd, 32'hA03456D0);
    check("t6_rd_lat", 32'(lat), 32'd28);
    check("t6_rd_accesses", 32'(nrd * 16 + nwr), 32'h20);
    stall = 0;

    check("rd_wr_exclusive", 32'(both_err), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
